// File: rtl/aqed_out_checker.sv
// aqed_out_checker
// Downstream consumer of the line-buffer core output stream in the A-QED
// harness. Counts valid output beats, captures the beat at an "original"
// index and at a "duplicate" index, then raises a sticky done flag along with
// a consistency result. The harness asserts qed_done |-> qed_check.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   clk_en       global enable; 0 holds every register (flush still applies)
//   flush        synchronous clear to the post-reset state
//   arm          single-cycle request to start a check with orig_idx/dup_idx
//   orig_idx     absolute output index of the original transaction
//   dup_idx      absolute output index of the duplicate transaction
//   acc_out_dat  accelerator output data
//   acc_out_v    accelerator output valid
//   out_count    valid beats seen since reset/flush, saturating
//   busy         check in progress (ARMED or GOT_ORIG)
//   qed_done     both captures complete, sticky
//   qed_check    0 only when done and the captured values differ
//   arm_err      sticky, an arm request was rejected
module aqed_out_checker #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              arm,
   input  logic [CNT_W-1:0]  orig_idx,
   input  logic [CNT_W-1:0]  dup_idx,
   input  logic [DATA_W-1:0] acc_out_dat,
   input  logic              acc_out_v,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy,
   output logic              qed_done,
   output logic              qed_check,
   output logic              arm_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      GOT_ORIG = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state_q,    state_d;
   logic [CNT_W-1:0]    count_d;
   logic [CNT_W-1:0]    orig_idx_q, orig_idx_d;
   logic [CNT_W-1:0]    dup_idx_q,  dup_idx_d;
   logic [DATA_W-1:0]   orig_val_q, orig_val_d;
   logic [DATA_W-1:0]   dup_val_q,  dup_val_d;
   logic                busy_d, done_d, check_d, arm_err_d;

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         out_count  <= '0;
         orig_idx_q <= '0;
         dup_idx_q  <= '0;
         orig_val_q <= '0;
         dup_val_q  <= '0;
         busy       <= 1'b0;
         qed_done   <= 1'b0;
         qed_check  <= 1'b1;
         arm_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_count  <= count_d;
         orig_idx_q <= orig_idx_d;
         dup_idx_q  <= dup_idx_d;
         orig_val_q <= orig_val_d;
         dup_val_q  <= dup_val_d;
         busy       <= busy_d;
         qed_done   <= done_d;
         qed_check  <= check_d;
         arm_err    <= arm_err_d;
      end
   end

   // Next-state, counter, capture and registered-output logic.
   // The index of a beat is out_count before its own increment. Once the
   // counter is pinned at CNT_MAX no capture can still be pending on CNT_MAX
   // (orig_idx < dup_idx <= CNT_MAX and arm requires orig_idx >= out_count),
   // so only the first beat at the maximum index can ever be captured.
   always_comb begin
      state_d    = state_q;
      count_d    = out_count;
      orig_idx_d = orig_idx_q;
      dup_idx_d  = dup_idx_q;
      orig_val_d = orig_val_q;
      dup_val_d  = dup_val_q;
      busy_d     = busy;
      done_d     = qed_done;
      check_d    = qed_check;
      arm_err_d  = arm_err;

      if (flush) begin
         state_d    = IDLE;
         count_d    = '0;
         orig_idx_d = '0;
         dup_idx_d  = '0;
         orig_val_d = '0;
         dup_val_d  = '0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         check_d    = 1'b1;
         arm_err_d  = 1'b0;
      end else if (clk_en) begin
         if (acc_out_v && (out_count != CNT_MAX)) begin
            count_d = out_count + CNT_W'(1);
         end

         case (state_q)
            IDLE: begin
               if (arm) begin
                  if ((orig_idx < dup_idx) && (orig_idx >= out_count)) begin
                     orig_idx_d = orig_idx;
                     dup_idx_d  = dup_idx;
                     // A beat at orig_idx in the arming cycle is captured too
                     if (acc_out_v && (out_count == orig_idx)) begin
                        orig_val_d = acc_out_dat;
                        state_d    = GOT_ORIG;
                     end else begin
                        state_d    = ARMED;
                     end
                  end else begin
                     arm_err_d = 1'b1;
                  end
               end
            end
            ARMED: begin
               if (acc_out_v && (out_count == orig_idx_q)) begin
                  orig_val_d = acc_out_dat;
                  state_d    = GOT_ORIG;
               end
            end
            GOT_ORIG: begin
               if (acc_out_v && (out_count == dup_idx_q)) begin
                  dup_val_d = acc_out_dat;
                  state_d   = DONE;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         busy_d  = (state_d == ARMED) || (state_d == GOT_ORIG);
         done_d  = (state_d == DONE);
         check_d = (state_d != DONE) || (orig_val_d == dup_val_d);
      end
   end

endmodule

// File: tb/tb_aqed_out_checker.sv
// Self-checking bench for aqed_out_checker. Each armed check pushes its
// expected {qed_check, out_count} onto a scoreboard when stimulus is driven;
// a monitor pops and compares whenever qed_done rises.
module tb_aqed_out_checker;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 16;

   typedef struct {
      logic             check;
      logic [CNT_W-1:0] count;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              clk_en;
   logic              flush;
   logic              arm;
   logic [CNT_W-1:0]  orig_idx;
   logic [CNT_W-1:0]  dup_idx;
   logic [DATA_W-1:0] acc_out_dat;
   logic              acc_out_v;
   logic [CNT_W-1:0]  out_count;
   logic              busy;
   logic              qed_done;
   logic              qed_check;
   logic              arm_err;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];
   logic done_prev = 1'b0;

   aqed_out_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .flush       (flush),
      .arm         (arm),
      .orig_idx    (orig_idx),
      .dup_idx     (dup_idx),
      .acc_out_dat (acc_out_dat),
      .acc_out_v   (acc_out_v),
      .out_count   (out_count),
      .busy        (busy),
      .qed_done    (qed_done),
      .qed_check   (qed_check),
      .arm_err     (arm_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stream input; arm and flush are single-cycle pulses
   task automatic beat(input logic v, input logic [DATA_W-1:0] d);
      acc_out_v   = v;
      acc_out_dat = d;
      @(negedge clk);
      acc_out_v = 1'b0;
      arm       = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_arm(input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] dd);
      arm      = 1'b1;
      orig_idx = o;
      dup_idx  = dd;
   endtask

   task automatic push_exp(input logic c, input logic [CNT_W-1:0] n);
      exp_t e;
      e.check = c;
      e.count = n;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: outputs only change at posedge, so sample at negedge
   always @(negedge clk) begin
      if (qed_done && !done_prev) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 32'(qed_done), 32'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_check", 32'(qed_check), 32'(e.check));
            chk("sb_count", 32'(out_count), 32'(e.count));
         end
      end
      done_prev = qed_done;
   end

   task automatic run_pair(input logic [DATA_W-1:0] last, input logic exp_check);
      push_exp(exp_check, CNT_W'(6));
      do_arm(CNT_W'(2), CNT_W'(5));
      beat(1'b0, '0);
      chk("armed_busy", 32'(busy), 32'(1));
      beat(1'b1, 16'd10);
      do_arm(CNT_W'(9), CNT_W'(1));            // arm outside IDLE is ignored
      beat(1'b1, 16'd11);
      chk("arm_ignored_err", 32'(arm_err), 32'(0));
      beat(1'b1, 16'h00AB);
      chk("got_orig_busy", 32'(busy), 32'(1));
      beat(1'b1, 16'd13);
      beat(1'b1, 16'd14);
      chk("pre_done", 32'(qed_done), 32'(0));
      beat(1'b1, last);
      chk("done_busy", 32'(busy), 32'(0));
      beat(1'b1, 16'h0000);
      beat(1'b1, 16'h00AB);
      chk("done_sticky", 32'(qed_done), 32'(1));
      chk("check_sticky", 32'(qed_check), 32'(exp_check));
      flush = 1'b1;
      beat(1'b1, 16'h00AB);
      chk("flush_done", 32'(qed_done), 32'(0));
      chk("flush_count", 32'(out_count), 32'(0));
      chk("flush_check", 32'(qed_check), 32'(1));
   endtask

   initial begin
      reset       = 1'b0;
      clk_en      = 1'b1;
      flush       = 1'b0;
      arm         = 1'b0;
      orig_idx    = '0;
      dup_idx     = '0;
      acc_out_dat = '0;
      acc_out_v   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_count", 32'(out_count), 32'(0));
      chk("rst_done", 32'(qed_done), 32'(0));
      chk("rst_check", 32'(qed_check), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_arm_err", 32'(arm_err), 32'(0));
      reset = 1'b1;
      @(negedge clk);

      // Matching and mismatching duplicate
      run_pair(16'h00AB, 1'b1);
      run_pair(16'h00AC, 1'b0);

      // Async reset while in GOT_ORIG with out_count=7
      do_arm(CNT_W'(6), CNT_W'(9));
      beat(1'b0, '0);
      for (int i = 0; i < 7; i++) beat(1'b1, 16'(i));
      chk("mid_busy", 32'(busy), 32'(1));
      chk("mid_count", 32'(out_count), 32'(7));
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_count", 32'(out_count), 32'(0));
      chk("mid_rst_done", 32'(qed_done), 32'(0));
      chk("mid_rst_check", 32'(qed_check), 32'(1));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      reset = 1'b1;
      @(negedge clk);

      // Rejected arms: orig == dup, then orig already passed
      do_arm(CNT_W'(4), CNT_W'(4));
      beat(1'b0, '0);
      chk("rej_eq_err", 32'(arm_err), 32'(1));
      chk("rej_eq_busy", 32'(busy), 32'(0));
      for (int i = 0; i < 3; i++) beat(1'b1, 16'(i));
      do_arm(CNT_W'(1), CNT_W'(5));
      beat(1'b0, '0);
      chk("rej_past_err", 32'(arm_err), 32'(1));
      chk("rej_past_busy", 32'(busy), 32'(0));

      // Arm with same-cycle beat at orig_idx; gated beat ignored
      push_exp(1'b1, CNT_W'(6));
      do_arm(CNT_W'(3), CNT_W'(5));
      beat(1'b1, 16'h0055);
      chk("same_cyc_busy", 32'(busy), 32'(1));
      chk("same_cyc_count", 32'(out_count), 32'(4));
      clk_en = 1'b0;
      beat(1'b1, 16'h0099);
      chk("gated_count", 32'(out_count), 32'(4));
      clk_en = 1'b1;
      beat(1'b1, 16'h0077);
      beat(1'b1, 16'h0055);
      chk("same_cyc_done", 32'(qed_done), 32'(1));
      chk("arm_err_sticky", 32'(arm_err), 32'(1));

      // Flush beats clk_en=0 while DONE
      clk_en = 1'b0;
      flush  = 1'b1;
      beat(1'b1, 16'h0001);
      chk("flush_ce0_done", 32'(qed_done), 32'(0));
      chk("flush_ce0_count", 32'(out_count), 32'(0));
      chk("flush_ce0_err", 32'(arm_err), 32'(0));
      chk("flush_ce0_busy", 32'(busy), 32'(0));
      clk_en = 1'b1;

      // Saturation: captures at FFFD and FFFF, then counter pinned
      for (int i = 0; i < 65533; i++) beat(1'b1, 16'(i));
      chk("sat_pre_count", 32'(out_count), 32'h0000_FFFD);
      push_exp(1'b1, CNT_W'(16'hFFFF));
      do_arm(CNT_W'(16'hFFFD), CNT_W'(16'hFFFF));
      beat(1'b1, 16'h1234);
      beat(1'b1, 16'h0000);
      beat(1'b1, 16'h1234);
      for (int i = 0; i < 3; i++) beat(1'b1, 16'h0005);
      chk("sat_count", 32'(out_count), 32'h0000_FFFF);
      chk("sat_done", 32'(qed_done), 32'(1));
      chk("sat_check", 32'(qed_check), 32'(1));

      chk("sb_drain", 32'(sb_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
